// File: rtl/fb_pixel_arbiter.sv
// rtl/fb_pixel_arbiter.sv - ring-buffer arbiter sharing one single-port pixel memory between writer and reader
// Optional start-of-frame tracking enabled by defining FB_PIXEL_ARBITER_SOF_EN.
module fb_pixel_arbiter #(
  parameter int DW    = 24,
  parameter int AW    = 10,
  parameter int DEPTH = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_sof,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          rd_sof,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW:0]   level
);

  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic          GNT_WR  = 1'b1;
  localparam logic          GNT_RD  = 1'b0;

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          inflight;
  logic          last_grant;

  logic wr_req;
  logic rd_req;
  logic wr_gnt;
  logic rd_gnt;

  // Round-robin on contention: the side that did not win last time goes now.
  always_comb begin
    wr_req = wr_valid && (count != FULL);
    rd_req = (count != '0) && !inflight && (!rd_valid || rd_ready);
    wr_gnt = wr_req && (!rd_req || last_grant == GNT_RD);
    rd_gnt = rd_req && (!wr_req || last_grant == GNT_WR);
  end

  assign wr_ready = (count != FULL) && !(rd_req && last_grant == GNT_WR);
  assign level    = count;

  always_comb begin
    mem_en    = wr_gnt || rd_gnt;
    mem_we    = wr_gnt;
    mem_addr  = rd_gnt ? rptr : wptr;
    mem_wdata = wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      inflight   <= 1'b0;
      last_grant <= GNT_RD;
    end else begin
      inflight <= rd_gnt;
      if (wr_gnt) begin
        wptr       <= wptr + PTR_ONE;
        count      <= count + CNT_ONE;
        last_grant <= GNT_WR;
      end else if (rd_gnt) begin
        rptr       <= rptr + PTR_ONE;
        count      <= count - CNT_ONE;
        last_grant <= GNT_RD;
      end
    end
  end

  // A reset during an inflight read clears inflight, so the stale mem_rdata is never captured.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (inflight) begin
      rd_valid <= 1'b1;
      rd_data  <= mem_rdata;
    end else if (rd_ready) begin
      rd_valid <= 1'b0;
    end
  end

`ifdef FB_PIXEL_ARBITER_SOF_EN
  logic [AW-1:0] sof_addr;
  logic          sof_pending;
  logic          sof_inflight;
  logic          rd_sof_q;
  logic          sof_hit;

  assign sof_hit = rd_gnt && sof_pending && (rptr == sof_addr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sof_addr     <= '0;
      sof_pending  <= 1'b0;
      sof_inflight <= 1'b0;
      rd_sof_q     <= 1'b0;
    end else begin
      if (wr_gnt && wr_sof) begin
        sof_pending <= 1'b1;
        sof_addr    <= wptr;
      end else if (sof_hit) begin
        sof_pending <= 1'b0;
      end
      sof_inflight <= sof_hit;
      if (inflight) begin
        rd_sof_q <= sof_inflight;
      end
    end
  end

  assign rd_sof = rd_sof_q;
`else
  logic unused_wr_sof;
  assign unused_wr_sof = wr_sof;
  assign rd_sof        = 1'b0;
`endif

endmodule

// File: tb/tb_fb_pixel_arbiter.sv
// tb/tb_fb_pixel_arbiter.sv - scoreboard bench for fb_pixel_arbiter with a registered-read memory model
module tb_fb_pixel_arbiter;

  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [23:0] wr_data;
  logic        wr_sof;
  logic        rd_valid;
  logic        rd_ready;
  logic [23:0] rd_data;
  logic        rd_sof;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [23:0] mem_wdata;
  logic [23:0] mem_rdata;
  logic [10:0] level;

  fb_pixel_arbiter #(.DW(24), .AW(10), .DEPTH(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_sof(wr_sof),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_sof(rd_sof),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] mem [1024];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

`ifdef FB_PIXEL_ARBITER_SOF_EN
  localparam bit SOF_EN = 1'b1;
`else
  localparam bit SOF_EN = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int first_rv_cyc = -1;
  int popped = 0;
  logic [24:0] sb [$];

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Output monitor: every consumer handshake is checked against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_valid && first_rv_cyc < 0) first_rv_cyc = cyc;
      if (rd_valid && rd_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", {8'h0, rd_data}, 32'hffff_ffff);
        end else begin
          logic [24:0] e;
          e = sb.pop_front();
          chk("rd_data", {8'h0, rd_data}, {8'h0, e[23:0]});
          chk("rd_sof", {31'h0, rd_sof}, {31'h0, e[24]});
          popped++;
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; wr_valid = 1'b0; wr_sof = 1'b0; wr_data = '0; rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    first_rv_cyc = -1;
    popped = 0;
  endtask

  task automatic write_px(input logic [23:0] d, input logic sof,
                          output logic [9:0] addr, output int acc_cyc);
    int n;
    bit done;
    n = 0; done = 1'b0; addr = '0; acc_cyc = -1;
    wr_valid = 1'b1; wr_data = d; wr_sof = sof;
    while (!done) begin
      @(negedge clk);
      if (wr_ready) begin
        sb.push_back({sof & SOF_EN, d});
        addr = mem_addr;
        acc_cyc = cyc;
        done = 1'b1;
      end else if (++n > 300) begin
        chk("write_timeout", 32'h0, 32'h1);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    wr_valid = 1'b0; wr_sof = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (sb.size() == 0 && level == 0 && !rd_valid) break;
      if (++n > bound) begin
        chk("drain_timeout", sb.size(), 32'h0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] a;
    int c0, c;
    logic [23:0] d;

    // Reset values
    do_reset();
    @(negedge clk);
    chk("rst_rd_valid", {31'h0, rd_valid}, 32'h0);
    chk("rst_level", {21'h0, level}, 32'h0);
    chk("rst_wr_ready", {31'h0, wr_ready}, 32'h1);
    chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
    chk("rst_rd_data", {8'h0, rd_data}, 32'h0);
    chk("rst_rd_sof", {31'h0, rd_sof}, 32'h0);
    @(posedge clk); #1;

    // Four pixels through an always-ready consumer
    rd_ready = 1'b1;
    write_px(24'h000001, 1'b0, a, c0);
    write_px(24'h000002, 1'b0, a, c);
    write_px(24'h000003, 1'b0, a, c);
    write_px(24'h000004, 1'b0, a, c);
    wait_drain(100);
    chk("latency", first_rv_cyc - c0, 32'd3);
    chk("t1_popped", popped, 32'd4);
    chk("t1_level", {21'h0, level}, 32'h0);

    // Fill to full with a stalled consumer, then release one pixel
    do_reset();
    for (int i = 0; i < 1025; i++) write_px(24'h100000 + 24'(i), 1'b0, a, c);
    repeat (2) @(negedge clk);
    chk("full_level", {21'h0, level}, 32'd1024);
    chk("full_wr_ready", {31'h0, wr_ready}, 32'h0);
    chk("full_rd_valid", {31'h0, rd_valid}, 32'h1);
    @(posedge clk); #1;
    rd_ready = 1'b1;
    @(negedge clk);
    chk("pulse_read_issue", {30'h0, mem_en, mem_we}, 32'h2);
    @(posedge clk); #1;
    rd_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("after_pulse_level", {21'h0, level}, 32'd1023);
    chk("after_pulse_wr_ready", {31'h0, wr_ready}, 32'h1);
    chk("after_pulse_rd_valid", {31'h0, rd_valid}, 32'h1);
    @(posedge clk); #1;
    rd_ready = 1'b1;
    wait_drain(5000);
    chk("t2_popped", popped, 32'd1025);

    // Continuous contention: accesses must strictly alternate write/read
    do_reset();
    rd_ready = 1'b1;
    d = 24'h200000;
    wr_valid = 1'b1; wr_data = d;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      chk("cont_mem_en", {31'h0, mem_en}, 32'h1);
      chk("cont_mem_we", {31'h0, mem_we}, (k % 2 == 0) ? 32'h1 : 32'h0);
      if (wr_ready) begin
        sb.push_back({1'b0, d});
        d = d + 24'h1;
      end
      @(posedge clk); #1;
      wr_data = d;
    end
    wr_valid = 1'b0;
    wait_drain(100);
    chk("t3_popped", popped, 32'd12);

    // Pointer wrap with continuous draining
    do_reset();
    rd_ready = 1'b1;
    for (int i = 0; i < 1030; i++) begin
      write_px(24'h300000 + 24'(i), 1'b0, a, c);
      if (i == 0 || i == 1023 || i == 1024 || i == 1029)
        chk("wrap_waddr", {22'h0, a}, i % 1024);
    end
    wait_drain(200);
    chk("wrap_popped", popped, 32'd1030);

    // Reset while a read is inflight
    do_reset();
    write_px(24'hABCDEF, 1'b0, a, c);
    @(negedge clk);
    chk("rst_mid_read_issue", {30'h0, mem_en, mem_we}, 32'h2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_rd_valid", {31'h0, rd_valid}, 32'h0);
    chk("rst_mid_level", {21'h0, level}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid_stale", {31'h0, rd_valid}, 32'h0);
    end
    @(posedge clk); #1;

    // Start-of-frame marker on the third of five pixels
    do_reset();
    rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) write_px(24'h400000 + 24'(i), (i == 2), a, c);
    wait_drain(100);
    chk("sof_popped", popped, 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout act=%0d exp=finish", cyc);
    $fatal(1);
  end

endmodule
